// File: rtl/fanin_rr_collector.sv
// Round-robin gather of NUM_SRC valid/ready sources into one registered output beat.
// Priority rotates only when a source beat is accepted, starting at source 0 after reset.
module fanin_rr_collector #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          beat_count
);

  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic            grant_vld;
  logic            load_en;
  logic            src_hs;
  logic            out_hs;

  // rst_n gates the load enable so no source sees ready while reset is held
  assign load_en = (!out_valid | out_ready) & rst_n;
  assign out_hs  = out_valid & out_ready;
  assign src_hs  = grant_vld & load_en;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_SRC);
      if (!grant_vld && src_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (src_hs) src_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      last_grant <= ID_W'(NUM_SRC - 1);
    end else if (src_hs) begin
      out_valid  <= 1'b1;
      out_data   <= src_data[int'(grant_idx)*DATA_W +: DATA_W];
      out_id     <= grant_idx;
      last_grant <= grant_idx;
    end else if (out_hs) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= '0;
    end else if (out_hs) begin
      beat_count <= beat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fanin_rr_collector.sv
// Directed-vector bench for fanin_rr_collector: table of per-cycle vectors plus
// hand-written reset, counter-wrap and mid-operation reset sequences.
module tb_fanin_rr_collector;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 4;
  localparam logic [31:0] DATA_STD = 32'h43_32_21_10;
  localparam logic [31:0] DATA_A5  = 32'h43_A5_21_10;
  localparam int NVEC = 21;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_ready;
  logic [CNT_W-1:0]          beat_count;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  exp_srdy;
    logic        exp_ov;
    logic [1:0]  exp_id;
    logic [7:0]  exp_data;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs [NVEC];

  fanin_rr_collector #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .beat_count (beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // round-robin fairness, 8 beats back to back
    vecs[0]  = '{4'b1111, DATA_STD, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 4'd0};
    vecs[1]  = '{4'b1111, DATA_STD, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h21, 4'd1};
    vecs[2]  = '{4'b1111, DATA_STD, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h32, 4'd2};
    vecs[3]  = '{4'b1111, DATA_STD, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h43, 4'd3};
    vecs[4]  = '{4'b1111, DATA_STD, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 4'd4};
    vecs[5]  = '{4'b1111, DATA_STD, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h21, 4'd5};
    vecs[6]  = '{4'b1111, DATA_STD, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h32, 4'd6};
    vecs[7]  = '{4'b1111, DATA_STD, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h43, 4'd7};
    vecs[8]  = '{4'b0000, DATA_STD, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h43, 4'd8};
    // skip and wrap from last_grant=2 with only sources 0,1 valid
    vecs[9]  = '{4'b0100, DATA_STD, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h32, 4'd8};
    vecs[10] = '{4'b0011, DATA_STD, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 4'd9};
    vecs[11] = '{4'b0011, DATA_STD, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h21, 4'd10};
    vecs[12] = '{4'b0000, DATA_STD, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h21, 4'd11};
    // backpressure holding 0xA5 from id 2, then release to id 3
    vecs[13] = '{4'b0100, DATA_A5,  1'b0, 4'b0100, 1'b1, 2'd2, 8'hA5, 4'd11};
    vecs[14] = '{4'b1111, DATA_STD, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 4'd11};
    vecs[15] = '{4'b1111, DATA_STD, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 4'd11};
    vecs[16] = '{4'b1111, DATA_STD, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 4'd11};
    vecs[17] = '{4'b1111, DATA_STD, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 4'd11};
    vecs[18] = '{4'b1111, DATA_STD, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 4'd11};
    vecs[19] = '{4'b1111, DATA_STD, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h43, 4'd12};
    vecs[20] = '{4'b0000, DATA_STD, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h43, 4'd13};

    // reset held with every source valid
    rst_n     = 1'b0;
    src_valid = 4'b1111;
    src_data  = DATA_STD;
    out_ready = 1'b0;
    repeat (2) edge_settle();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_id", 32'(out_id), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset beat_count", 32'(beat_count), 32'd0);
    check("reset src_ready", 32'(src_ready), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      src_valid = vecs[i].v;
      src_data  = vecs[i].data;
      out_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d src_ready", i), 32'(src_ready), 32'(vecs[i].exp_srdy));
      edge_settle();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d out_id", i), 32'(out_id), 32'(vecs[i].exp_id));
      check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d beat_count", i), 32'(beat_count), 32'(vecs[i].exp_cnt));
    end

    // counter wrap: continuous stream from source 0 after a fresh reset
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    src_valid = 4'b0001;
    src_data  = DATA_STD;
    out_ready = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      edge_settle();
      check($sformatf("wrap edge%0d beat_count", n), 32'(beat_count), 32'((n - 1) % 16));
    end

    // move last_grant to 1, then reset between edges with a beat held
    src_valid = 4'b0010;
    edge_settle();
    check("pre-reset out_id", 32'(out_id), 32'd1);
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset beat_count", 32'(beat_count), 32'd0);
    check("midreset src_ready", 32'(src_ready), 32'd0);
    rst_n     = 1'b1;
    src_valid = 4'b0110;
    #1;
    check("post-reset src_ready", 32'(src_ready), 32'b0010);
    edge_settle();
    check("post-reset out_id", 32'(out_id), 32'd1);
    check("post-reset out_data", 32'(out_data), 32'h21);
    check("post-reset out_valid", 32'(out_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fanin_rr_collector.md
Name: fanin_rr_collector

Overview:
- Return-path counterpart of a single-driver fanout tree: collects beats from NUM_SRC load-side sources and delivers them to one sink.
- Round-robin arbitration across sources, with one registered output stage.
- Used as the gather end of hierarchical resizer test designs, so that buffer-insertion flows see fan-in nets driven through sequential logic.

Parameters:
- NUM_SRC, 4, number of source ports (≥2).
- DATA_W, 8, data width per source.
- ID_W, 2, width of source index; must equal ceil(log2(NUM_SRC)).
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- src_valid  input  NUM_SRC  per-source beat valid.
- src_data  input  NUM_SRC*DATA_W  packed source data; source i occupies bits [i*DATA_W +: DATA_W].
- src_ready  output  NUM_SRC  per-source accept; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered beat data.
- out_id  output  ID_W  index of the source that supplied out_data.
- out_ready  input  1  sink accept.
- beat_count  output  CNT_W  number of output handshakes completed, modulo 2^CNT_W.

Behaviour:
- Reset values (asserted asynchronously while rst_n=0):
  - out_valid=0, out_data=0, out_id=0, beat_count=0.
  - Round-robin pointer last_grant=NUM_SRC-1, so source 0 has first priority.
  - src_ready=0 for all sources.
- Load enable: load_en = !out_valid | out_ready. It is combinational.
- Arbitration (combinational):
  - When load_en=1, scan from (last_grant+1) mod NUM_SRC upward with wrap-around.
  - The first i with src_valid[i]=1 becomes the grant g, and src_ready[g]=1.
  - All other src_ready bits are 0.
  - If no source is valid, or load_en=0, all src_ready bits are 0.
- Source handshake: src_valid[g] & src_ready[g]. At the next edge:
  - out_data <= src_data[g], out_id <= g, out_valid <= 1, last_grant <= g.
- Output handshake: out_valid & out_ready.
  - beat_count increments by 1 and wraps from 2^CNT_W-1 to 0.
  - If no source handshake occurs in the same cycle, out_valid <= 0.
  - out_data and out_id keep their last values.
- Simultaneous drain and load in one cycle:
  - The new beat replaces the old one; out_valid stays 1.
  - This sustains 1 beat/cycle throughput.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data, out_id and out_valid hold stable.
  - All src_ready bits are 0.
- Latency: a beat accepted at edge k appears on out_* after edge k (1 cycle, src -> out).
- last_grant changes only on a source handshake. Idle cycles do not rotate priority.
- Protocol obligations:
  - Sources may change src_data or drop src_valid before their handshake. The block never latches a beat without a handshake.
  - The sink must not rely on out_data when out_valid=0.
- Reset mid-operation: any held beat is discarded with no handshake; the next grant again starts at source 0.
- No combinational path from out_ready to out_data, out_id or out_valid. A path from out_ready to src_ready is permitted.

Test Plan:
- Reset: hold rst_n=0 with all src_valid=1 -> out_valid=0, beat_count=0, src_ready=0000. Release -> first grant is src 0; out_id=0 after 1 edge.
- Round-robin fairness: src_valid=1111, data 0x10/0x21/0x32/0x43, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3; out_data matches per id; beat_count=8.
- Skip and wrap: last_grant=2, src_valid=0011 -> grant 0 then 1; out_id 0,1; no cycle is wasted on invalid sources.
- Backpressure: out_valid=1 holding 0xA5 from id 2, out_ready=0 for 5 cycles while src_valid=1111 -> out_data=0xA5 stable, src_ready=0000. Assert out_ready -> next beat from id 3 on the following edge.
- Counter wrap: with CNT_W=4, perform 17 output handshakes -> beat_count reads 15 after the 15th handshake, 0 after the 16th, 1 after the 17th.
- Mid-operation reset: pulse rst_n low asynchronously between edges while out_valid=1 -> out_valid=0 immediately. After release with src_valid=0110 -> first out_id=1.
